operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max idle cycles between serial bits before a load aborts (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, one-cycle request to begin loading a new operand pair.
REQ-005 SHALL have port ser_in, input, 1, serial operand data bit.
REQ-006 SHALL have port ser_valid, input, 1, ser_in qualifier; one bit consumed per cycle it is high.
REQ-007 SHALL have ports a0, a1, a2, a3, output, 1 each, operand A bits (a3 = MSB), driving the comparator a-inputs.
REQ-008 SHALL have ports b0, b1, b2, b3, output, 1 each, operand B bits (b3 = MSB), driving the comparator b-inputs.
REQ-009 SHALL have port op_valid, output, 1, one-cycle pulse when a new operand pair is committed.
REQ-010 SHALL have port busy, output, 1, high while a load is in progress.
REQ-011 SHALL have port timeout_err, output, 1, one-cycle pulse on load abort by timeout.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, HOLD (plus LOAD_P under REQ-025).
REQ-013 SHALL move IDLE or HOLD -> LOAD_A on start=1, clearing bit counter and timeout counter.
REQ-014 SHALL ignore start while in LOAD_A, LOAD_B or LOAD_P.
REQ-015 SHALL, in LOAD_A/LOAD_B, shift ser_in MSB-first into a shadow register on each cycle with ser_valid=1; a ser_valid high in the same cycle as the start that enters LOAD_A is not consumed.
REQ-016 SHALL move LOAD_A -> LOAD_B after the 4th accepted bit, and LOAD_B -> HOLD after the 4th accepted B bit.
REQ-017 SHALL commit both shadow registers to a0..a3/b0..b3 simultaneously on the clock edge entering HOLD, with op_valid high for exactly that following cycle (latency: 1 cycle after last bit).
REQ-018 SHALL keep a0..a3/b0..b3 unchanged at all other times, including during a new load, on abort and on timeout.
REQ-019 SHALL drive busy=1 exactly in LOAD_A, LOAD_B, LOAD_P.
REQ-020 SHALL count consecutive load-state cycles with ser_valid=0, resetting on ser_valid=1; on reaching TIMEOUT_CYCLES go to IDLE, pulse timeout_err one cycle, discard shadow data.
REQ-021 SHALL saturate, never wrap, the timeout counter (8 bits).

Reset
REQ-022 SHALL, on rst_n=0, immediately force state IDLE, all operand outputs 0, op_valid/busy/timeout_err/parity_err 0, counters and shadows 0.
REQ-023 SHALL discard any in-progress load on reset; no op_valid follows reset release.
REQ-024 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with macro OPERAND_LOADER_PARITY_EN defined, add state LOAD_P after LOAD_B consuming one even-parity bit over the 8 data bits; match -> commit as REQ-017; mismatch -> IDLE, no commit, parity_err output (1 bit) pulses one cycle.
REQ-026 SHALL, without OPERAND_LOADER_PARITY_EN, omit LOAD_P and the parity_err port entirely.

Structure
REQ-027 SHALL place the FSM state enum, OP_BITS=4 and timeout counter width constant in package operand_loader_pkg.
REQ-028 SHALL implement the timeout counter as sub-module operand_loader_timeout (inputs clear, tick; output expired).

Verification
REQ-029 SHALL test: reset, start, bits 1,0,0,1 then 1,0,0,1 -> a3..a0=1001, b3..b0=1001, op_valid one cycle, comparator equals=1.
REQ-030 SHALL test: A=0111, B=1000 with ser_valid gaps of 3 cycles -> commit after 8th bit, b_bigger=1, busy low after commit.
REQ-031 SHALL test: TIMEOUT_CYCLES=4, 2 bits sent then ser_valid=0 for 4 cycles -> timeout_err pulse, state IDLE, outputs keep prior 1001/1001.
REQ-032 SHALL test: start pulsed again mid-LOAD_B -> ignored, load completes with original bits.
REQ-033 SHALL test: rst_n low during LOAD_A after 3 bits -> outputs 0 immediately, no op_valid after release.
REQ-034 SHALL test (OPERAND_LOADER_PARITY_EN): A=1001, B=0001, parity bit 0 -> parity_err pulse, no commit; parity bit 1 -> commit.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared types and constants for the serial operand loader.
// OPERAND_LOADER_PARITY_EN adds the LOAD_P state to the FSM encoding.
package operand_loader_pkg;

    localparam int OP_BITS = 4;   // width of each operand
    localparam int TMO_W   = 8;   // width of the idle/timeout counter

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        HOLD   = 3'd3
`ifdef OPERAND_LOADER_PARITY_EN
        , LOAD_P = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/operand_loader_timeout.sv
// operand_loader_timeout: saturating count of consecutive idle load cycles.
// expired is combinational so the FSM can abort on the cycle the limit is hit.
module operand_loader_timeout
    import operand_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [TMO_W-1:0] LIMIT   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] CNT_MAX = '1;

    logic [TMO_W-1:0] cnt;

    // Idle-cycle counter: cleared on any accepted bit or outside a load, sticks at max
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // This idle cycle is the TIMEOUT_CYCLES-th consecutive one
    assign expired = tick && !clear && (cnt >= LIMIT);

endmodule

// File: rtl/operand_loader.sv
// operand_loader: shifts an A/B operand pair in MSB-first over a 1-bit serial link
// and commits both to the comparator inputs at once.
// Optional: define OPERAND_LOADER_PARITY_EN for a trailing even-parity bit and parity_err.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ser_in,
    input  logic ser_valid,
    output logic a0,
    output logic a1,
    output logic a2,
    output logic a3,
    output logic b0,
    output logic b1,
    output logic b2,
    output logic b3,
    output logic op_valid,
    output logic busy,
    output logic timeout_err
`ifdef OPERAND_LOADER_PARITY_EN
    ,
    output logic parity_err
`endif
);

    localparam int               CNT_W    = $clog2(OP_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OP_BITS - 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [OP_BITS-1:0]   sh_a, sh_a_nxt, sh_b, sh_b_nxt;
    logic [OP_BITS-1:0]   op_a, op_a_nxt, op_b, op_b_nxt;
    logic [OP_BITS-1:0]   sh_a_shift, sh_b_shift;
    logic                 op_valid_nxt, timeout_err_nxt;
    logic                 loading, expired;
`ifdef OPERAND_LOADER_PARITY_EN
    logic                 parity_err_nxt;
`endif

    assign sh_a_shift = {sh_a[OP_BITS-2:0], ser_in};
    assign sh_b_shift = {sh_b[OP_BITS-2:0], ser_in};

    // Load-state decode drives both busy and the idle counter
    always_comb begin
        loading = (state == LOAD_A) || (state == LOAD_B);
`ifdef OPERAND_LOADER_PARITY_EN
        if (state == LOAD_P) loading = 1'b1;
`endif
    end

    assign busy = loading;

    operand_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!loading || ser_valid),
        .tick   (loading && !ser_valid),
        .expired(expired)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and datapath updates; a timeout overrides whatever the state did
    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        sh_a_nxt        = sh_a;
        sh_b_nxt        = sh_b;
        op_a_nxt        = op_a;
        op_b_nxt        = op_b;
        op_valid_nxt    = 1'b0;
        timeout_err_nxt = 1'b0;
`ifdef OPERAND_LOADER_PARITY_EN
        parity_err_nxt  = 1'b0;
`endif
        unique case (state)
            IDLE, HOLD: begin
                // ser_valid in the start cycle is deliberately not consumed
                if (start) begin
                    state_nxt   = LOAD_A;
                    bit_cnt_nxt = '0;
                    sh_a_nxt    = '0;
                    sh_b_nxt    = '0;
                end
            end
            LOAD_A: begin
                if (ser_valid) begin
                    sh_a_nxt    = sh_a_shift;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                if (ser_valid) begin
                    sh_b_nxt    = sh_b_shift;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef OPERAND_LOADER_PARITY_EN
                        state_nxt    = LOAD_P;
`else
                        state_nxt    = HOLD;
                        op_a_nxt     = sh_a;
                        op_b_nxt     = sh_b_shift;
                        op_valid_nxt = 1'b1;
`endif
                    end
                end
            end
`ifdef OPERAND_LOADER_PARITY_EN
            LOAD_P: begin
                if (ser_valid) begin
                    if (ser_in == ^{sh_a, sh_b}) begin
                        state_nxt    = HOLD;
                        op_a_nxt     = sh_a;
                        op_b_nxt     = sh_b;
                        op_valid_nxt = 1'b1;
                    end else begin
                        state_nxt      = IDLE;
                        sh_a_nxt       = '0;
                        sh_b_nxt       = '0;
                        parity_err_nxt = 1'b1;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        if (expired) begin
            state_nxt       = IDLE;
            sh_a_nxt        = '0;
            sh_b_nxt        = '0;
            timeout_err_nxt = 1'b1;
        end
    end

    // Datapath and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            sh_a        <= '0;
            sh_b        <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_valid    <= 1'b0;
            timeout_err <= 1'b0;
`ifdef OPERAND_LOADER_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            bit_cnt     <= bit_cnt_nxt;
            sh_a        <= sh_a_nxt;
            sh_b        <= sh_b_nxt;
            op_a        <= op_a_nxt;
            op_b        <= op_b_nxt;
            op_valid    <= op_valid_nxt;
            timeout_err <= timeout_err_nxt;
`ifdef OPERAND_LOADER_PARITY_EN
            parity_err  <= parity_err_nxt;
`endif
        end
    end

    assign {a3, a2, a1, a0} = op_a;
    assign {b3, b2, b1, b0} = op_b;

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed and random checks of operand_loader against a queue-based model.
module tb_operand_loader;

    localparam int TMO = 4;
`ifdef OPERAND_LOADER_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic clk = 1'b0;
    logic rst_n, start, ser_in, ser_valid;
    logic a0, a1, a2, a3, b0, b1, b2, b3;
    logic op_valid, busy, timeout_err;
`ifdef OPERAND_LOADER_PARITY_EN
    logic parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit       m_loading;
    bit       m_bits[$];
    int       m_idle;
    bit [3:0] exp_a, exp_b;
    bit       exp_ov, exp_te, exp_pe;

    operand_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ser_in(ser_in), .ser_valid(ser_valid),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .op_valid(op_valid), .busy(busy), .timeout_err(timeout_err)
`ifdef OPERAND_LOADER_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        logic pe;
`ifdef OPERAND_LOADER_PARITY_EN
        pe = parity_err;
`else
        pe = 1'b0;
`endif
        return {op_valid, timeout_err, pe, busy, a3, a2, a1, a0, b3, b2, b1, b0};
    endfunction

    function automatic logic [11:0] expv();
        return {exp_ov, exp_te, exp_pe, m_loading, exp_a, exp_b};
    endfunction

    function automatic bit [3:0] pack4(input int base);
        bit [3:0] v = '0;
        for (int i = 0; i < 4; i++) v = {v[2:0], m_bits[base + i]};
        return v;
    endfunction

    function automatic bit par_ok();
        bit x = 1'b0;
        for (int i = 0; i < m_bits.size(); i++) x ^= m_bits[i];
`ifdef OPERAND_LOADER_PARITY_EN
        return (x == 1'b0);
`else
        return (x == x);
`endif
    endfunction

    task automatic model_reset();
        m_loading = 0; m_bits.delete(); m_idle = 0;
        exp_a = '0; exp_b = '0; exp_ov = 0; exp_te = 0; exp_pe = 0;
    endtask

    // One serial transaction is a start then NBITS accepted bits; idle runs of TMO abort it
    task automatic model_step(input bit st, input bit sv, input bit si);
        exp_ov = 0; exp_te = 0; exp_pe = 0;
        if (!m_loading) begin
            if (st) begin
                m_loading = 1; m_bits.delete(); m_idle = 0;
            end
        end else if (sv) begin
            m_idle = 0;
            m_bits.push_back(si);
            if (m_bits.size() == NBITS) begin
                m_loading = 0;
                if (par_ok()) begin
                    exp_a = pack4(0); exp_b = pack4(4); exp_ov = 1;
                end else begin
                    exp_pe = 1;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                m_loading = 0; exp_te = 1;
            end
        end
    endtask

    task automatic cycle(input bit st, input bit sv, input bit si);
        start = st; ser_valid = sv; ser_in = si;
        model_step(st, sv, si);
        @(posedge clk); #1;
        start = 1'b0; ser_valid = 1'b0; ser_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ser_valid = 1'b0; ser_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== 12'h000) begin
            n_bad++; $display("FAIL reset: got %b want %b", obs(), 12'h000);
        end
        rst_n = 1'b1;
        cycle(0, 1, 1);
        n_cmp++;
        if (obs() !== expv()) begin
            n_bad++; $display("FAIL reset_release: got %b want %b", obs(), expv());
        end
    endtask

    task automatic test_basic();
        bit [7:0] pat = 8'b1001_1001;
        cycle(1, 0, 0);
        for (int i = 7; i >= -2; i--) begin
            if (i >= 0) cycle(0, 1, pat[i]);
            else        cycle(0, 0, 0);
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL basic[%0d]: got %b want %b", i, obs(), expv());
            end
        end
        n_cmp++;
        if (({a3, a2, a1, a0} == {b3, b2, b1, b0}) !== 1'b1) begin
            n_bad++; $display("FAIL basic_equals: got a=%b b=%b want equal 1001", {a3, a2, a1, a0}, {b3, b2, b1, b0});
        end
    endtask

    task automatic test_timeout();
        cycle(1, 0, 0);
        cycle(0, 1, 1);
        cycle(0, 1, 0);
        for (int i = 0; i < TMO + 2; i++) begin
            cycle(0, 0, 0);
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL timeout[%0d]: got %b want %b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_gaps();
        bit [7:0] pat = 8'b0111_1000;
        cycle(1, 0, 0);
        for (int i = 7; i >= 0; i--) begin
            for (int g = 0; g < 3; g++) begin
                cycle(0, 0, 1);
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++; $display("FAIL gaps_idle[%0d.%0d]: got %b want %b", i, g, obs(), expv());
                end
            end
            cycle(0, 1, pat[i]);
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL gaps_bit[%0d]: got %b want %b", i, obs(), expv());
            end
        end
        n_cmp++;
        if (({b3, b2, b1, b0} > {a3, a2, a1, a0}) !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL gaps_b_bigger: got a=%b b=%b busy=%b want a=0111 b=1000 busy=0",
                              {a3, a2, a1, a0}, {b3, b2, b1, b0}, busy);
        end
    endtask

    task automatic test_start_mid();
        bit [7:0] pat = 8'b1100_0101;
        cycle(1, 1, 1);  // bit alongside start must not be taken
        for (int i = 7; i >= 0; i--) begin
            cycle(i == 2 || i == 1, 1, pat[i]);
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL start_mid[%0d]: got %b want %b", i, obs(), expv());
            end
        end
        n_cmp++;
        if ({a3, a2, a1, a0, b3, b2, b1, b0} !== pat) begin
            n_bad++; $display("FAIL start_mid_value: got %b want %b", {a3, a2, a1, a0, b3, b2, b1, b0}, pat);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (obs() !== 12'h000) begin
            n_bad++; $display("FAIL reset_mid_async: got %b want %b", obs(), 12'h000);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 1);
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL reset_mid_after[%0d]: got %b want %b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL rand_start[%0d]: got %b want %b", t, obs(), expv());
            end
            for (int c = 0; c < 200 && m_loading; c++) begin
                cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)));
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++; $display("FAIL rand[%0d.%0d]: got %b want %b", t, c, obs(), expv());
                end
            end
            n_cmp++;
            if (m_loading) begin
                n_bad++; $display("FAIL rand_budget[%0d]: got busy=%b want load finished", t, busy);
            end
            repeat ($urandom_range(0, 2)) begin
                cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++; $display("FAIL rand_hold[%0d]: got %b want %b", t, obs(), expv());
                end
            end
        end
    endtask

`ifdef OPERAND_LOADER_PARITY_EN
    task automatic test_parity();
        bit [8:0] pat;
        for (int k = 0; k < 2; k++) begin
            pat = {8'b1001_0001, 1'(k)};
            cycle(1, 0, 0);
            for (int i = 8; i >= -1; i--) begin
                if (i >= 0) cycle(0, 1, pat[i]);
                else        cycle(0, 0, 0);
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++; $display("FAIL parity%0d[%0d]: got %b want %b", k, i, obs(), expv());
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_gaps();
        test_start_mid();
        test_reset_mid();
        test_random();
`ifdef OPERAND_LOADER_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
